// File: rtl/jtpang_eeprom.sv
// Purpose: 93C46-style serial EEPROM model, 64 x 16-bit words, with a byte-wide dump/restore port.
// Latency: sdo is registered one clk after the sclk edge is detected; prog_din follows prog_addr by 1 clk.
// Backpressure: none; the host is paced by sclk, and bulk programming runs for BUSY_CYC clks with sdo held low.
module jtpang_eeprom #(
  parameter int BUSY_CYC = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       sdi,
  output logic       sdo,
  input  logic [6:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       prog_we,
  output logic [7:0] prog_din
);

  // One extra bit so that the "< 64" bulk-write window test also holds when BUSY_CYC is exactly 64
  localparam int BW = $clog2(BUSY_CYC) + 1;

  typedef enum logic [2:0] {IDLE, CMD, READ, WDATA, WAIT_CS, BUSY} state_t;

  state_t         state, state_nx;
  logic           sclk_q;
  logic           sclk_rise;
  logic           sdo_nx;
  logic           wen, wen_nx;
  logic [3:0]     cnt, cnt_nx;
  logic [7:0]     cmd_sr, cmd_nx;
  logic [15:0]    dat_sr, dat_nx;
  logic [BW-1:0]  busy_cnt, busy_nx;
  logic           mem_we;
  logic           ser_we;
  logic [5:0]     mem_wa;
  logic [15:0]    mem_wd;
  logic [15:0]    mem [64];

  // Opcode decode on the latched command; cmd_sr is {op[1:0], addr[5:0]}
  logic [1:0] op, ext;
  logic       is_write, is_erase, is_wral, is_eral, bulk, use_data, commit_ok;
  assign op        = cmd_sr[7:6];
  assign ext       = cmd_sr[5:4];
  assign is_write  = (op == 2'b01);
  assign is_erase  = (op == 2'b11);
  assign is_wral   = (op == 2'b00) && (ext == 2'b01);
  assign is_eral   = (op == 2'b00) && (ext == 2'b10);
  assign bulk      = is_wral | is_eral;
  assign use_data  = is_write | is_wral;
  assign commit_ok = wen & (is_write | is_erase | bulk);
  assign sclk_rise = sclk & ~sclk_q;
  // Reset must cut a bulk loop short without touching words already written
  assign ser_we    = mem_we & ~rst;

  // State and datapath registers; memory contents are deliberately outside reset
  always_ff @(posedge clk) begin
    sclk_q <= sclk;
    if (rst) begin
      state    <= IDLE;
      sdo      <= 1'b1;
      wen      <= 1'b0;
      cnt      <= '0;
      cmd_sr   <= '0;
      dat_sr   <= '0;
      busy_cnt <= '0;
    end else begin
      state    <= state_nx;
      sdo      <= sdo_nx;
      wen      <= wen_nx;
      cnt      <= cnt_nx;
      cmd_sr   <= cmd_nx;
      dat_sr   <= dat_nx;
      busy_cnt <= busy_nx;
    end
  end

  // Next-state, serial shifting, commit decisions and memory write request
  always_comb begin
    state_nx = state;
    sdo_nx   = sdo;
    wen_nx   = wen;
    cnt_nx   = cnt;
    cmd_nx   = cmd_sr;
    dat_nx   = dat_sr;
    busy_nx  = busy_cnt;
    mem_we   = 1'b0;
    mem_wa   = cmd_sr[5:0];
    mem_wd   = use_data ? dat_sr : 16'hFFFF;
    if (state == BUSY) begin
      sdo_nx  = 1'b0;
      busy_nx = busy_cnt + 1'b1;
      if (bulk && busy_cnt < BW'(64)) begin
        mem_we = 1'b1;
        mem_wa = busy_cnt[5:0];
      end
      if (busy_cnt == BW'(BUSY_CYC - 1)) begin
        state_nx = IDLE;
        sdo_nx   = 1'b1;
        busy_nx  = '0;
      end
    end else if (!cs) begin
      state_nx = IDLE;
      sdo_nx   = 1'b1;
      if (state == WAIT_CS && commit_ok) begin
        state_nx = BUSY;
        sdo_nx   = 1'b0;
        busy_nx  = '0;
        mem_we   = !bulk;
      end
    end else if (sclk_rise) begin
      case (state)
        IDLE: begin
          if (sdi) begin
            state_nx = CMD;
            cnt_nx   = '0;
          end
        end
        CMD: begin
          cmd_nx = {cmd_sr[6:0], sdi};
          cnt_nx = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_nx = '0;
            case (cmd_nx[7:6])
              2'b10: begin
                state_nx = READ;
                sdo_nx   = 1'b0;
              end
              2'b01: state_nx = WDATA;
              2'b11: state_nx = WAIT_CS;
              default: begin
                state_nx = (cmd_nx[5:4] == 2'b01) ? WDATA : WAIT_CS;
                if (cmd_nx[5:4] == 2'b11) wen_nx = 1'b1;
                if (cmd_nx[5:4] == 2'b00) wen_nx = 1'b0;
              end
            endcase
          end
        end
        READ: begin
          sdo_nx = mem[cmd_sr[5:0]][~cnt];
          cnt_nx = cnt + 4'd1;
          if (cnt == 4'd15) cmd_nx[5:0] = cmd_sr[5:0] + 6'd1;
        end
        WDATA: begin
          dat_nx = {dat_sr[14:0], sdi};
          cnt_nx = cnt + 4'd1;
          if (cnt == 4'd15) state_nx = WAIT_CS;
        end
        default: ;
      endcase
    end
  end

  // Memory writes: prog restore byte merge, then serial commit which wins on the same word
  always_ff @(posedge clk) begin
    if (prog_we && !(ser_we && mem_wa == prog_addr[6:1])) begin
      if (prog_addr[0]) mem[prog_addr[6:1]][7:0]  <= prog_data;
      else              mem[prog_addr[6:1]][15:8] <= prog_data;
    end
    if (ser_we) mem[mem_wa] <= mem_wd;
  end

  // Dump port: high byte at even byte addresses
  always_ff @(posedge clk) begin
    prog_din <= prog_addr[0] ? mem[prog_addr[6:1]][7:0] : mem[prog_addr[6:1]][15:8];
  end

endmodule
